// File: rtl/dmem_access_ctrl_pkg.sv
// Shared types and sizing for the data-memory access controller.
// The state encoding and RAM geometry defaults live here.
package dmem_access_ctrl_pkg;

    localparam int DSIZE_DEF  = 16;
    localparam int AWIDTH_DEF = 10;
    localparam int RAM_DEPTH  = 1024;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Pipeline request/response and RAM port bundle for dmem_access_ctrl.
// master = the controller (initiator), slave = pipeline stage plus RAM.
interface dmem_access_ctrl_if
    import dmem_access_ctrl_pkg::*;
#(
    parameter int DSIZE  = DSIZE_DEF,
    parameter int AWIDTH = AWIDTH_DEF
) ();

    logic              Req_Valid;
    logic              Req_Write;
    logic [DSIZE-1:0]  Req_Addr;
    logic [DSIZE-1:0]  Req_Wdata;
    logic              Req_Ready;
    logic              Rsp_Valid;
    logic              Rsp_Ready;
    logic [DSIZE-1:0]  Rsp_Rdata;
    logic              Rsp_Err;
    logic              Mem_Enable;
    logic              Mem_Write_Enab;
    logic [AWIDTH-1:0] Mem_Add;
    logic [DSIZE-1:0]  Mem_Wdata;
    logic [DSIZE-1:0]  Mem_Rdata;

    modport master (
        input  Req_Valid, Req_Write, Req_Addr, Req_Wdata, Rsp_Ready, Mem_Rdata,
        output Req_Ready, Rsp_Valid, Rsp_Rdata, Rsp_Err,
        output Mem_Enable, Mem_Write_Enab, Mem_Add, Mem_Wdata
    );

    modport slave (
        output Req_Valid, Req_Write, Req_Addr, Req_Wdata, Rsp_Ready, Mem_Rdata,
        input  Req_Ready, Rsp_Valid, Rsp_Rdata, Rsp_Err,
        input  Mem_Enable, Mem_Write_Enab, Mem_Add, Mem_Wdata
    );

endinterface

// File: rtl/dmem_access_ctrl.sv
// Load/store initiator for the 1024x16 single-port data RAM (one-cycle read).
// Optional out-of-range address checking is enabled by defining DMEM_ERR_CHECK_EN.
//
// state   | meaning
// IDLE    | Req_Ready high, waiting for a request
// ACCESS  | RAM enabled for one cycle (write-enable = latched store flag)
// CAPTURE | RAM output valid, copied into the rdata register
// RESP    | Rsp_Valid high, held until Rsp_Ready
module dmem_access_ctrl
    import dmem_access_ctrl_pkg::*;
#(
    parameter int DSIZE  = DSIZE_DEF,
    parameter int AWIDTH = AWIDTH_DEF
) (
    input  logic               Clk_In,
    input  logic               Rst_In,
    dmem_access_ctrl_if.master bus
);

    state_t            state;
    logic              req_ready_q;
    logic              rsp_valid_q;
    logic              mem_en_q;
    logic              mem_we_q;
    logic              wr_q;
    logic [AWIDTH-1:0] addr_q;
    logic [DSIZE-1:0]  wdata_q;
    logic [DSIZE-1:0]  rdata_q;

`ifdef DMEM_ERR_CHECK_EN
    logic err_q;
    logic out_of_range;

    assign out_of_range = |bus.Req_Addr[DSIZE-1:AWIDTH];
`endif

    always_ff @(posedge Clk_In or posedge Rst_In) begin
        if (Rst_In) begin
            state       <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
`ifdef DMEM_ERR_CHECK_EN
            err_q       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.Req_Valid) begin
                        wr_q        <= bus.Req_Write;
                        addr_q      <= bus.Req_Addr[AWIDTH-1:0];
                        wdata_q     <= bus.Req_Wdata;
                        req_ready_q <= 1'b0;
`ifdef DMEM_ERR_CHECK_EN
                        // Out-of-range requests skip the RAM entirely.
                        if (out_of_range) begin
                            state       <= RESP;
                            rsp_valid_q <= 1'b1;
                            rdata_q     <= '0;
                            err_q       <= 1'b1;
                        end else begin
                            state    <= ACCESS;
                            mem_en_q <= 1'b1;
                            mem_we_q <= bus.Req_Write;
                        end
`else
                        state    <= ACCESS;
                        mem_en_q <= 1'b1;
                        mem_we_q <= bus.Req_Write;
`endif
                    end
                end
                ACCESS: begin
                    mem_en_q <= 1'b0;
                    mem_we_q <= 1'b0;
                    if (wr_q) begin
                        state       <= RESP;
                        rsp_valid_q <= 1'b1;
                        rdata_q     <= '0;
                    end else begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    rdata_q     <= bus.Mem_Rdata;
                    rsp_valid_q <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    if (bus.Rsp_Ready) begin
                        rsp_valid_q <= 1'b0;
                        rdata_q     <= '0;
                        req_ready_q <= 1'b1;
                        state       <= IDLE;
`ifdef DMEM_ERR_CHECK_EN
                        err_q       <= 1'b0;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.Req_Ready      = req_ready_q;
    assign bus.Rsp_Valid      = rsp_valid_q;
    assign bus.Rsp_Rdata      = rdata_q;
    assign bus.Mem_Enable     = mem_en_q;
    assign bus.Mem_Write_Enab = mem_we_q;
    assign bus.Mem_Add        = addr_q;
    assign bus.Mem_Wdata      = wdata_q;

`ifdef DMEM_ERR_CHECK_EN
    assign bus.Rsp_Err = err_q;
`else
    assign bus.Rsp_Err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl with a behavioural 1024x16 WRITE_FIRST RAM.
// Honours DMEM_ERR_CHECK_EN so the same bench covers both builds.
module tb_dmem_access_ctrl;
    import dmem_access_ctrl_pkg::*;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    dmem_access_ctrl_if bus ();

    dmem_access_ctrl dut (
        .Clk_In (clk),
        .Rst_In (rst),
        .bus    (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] init_val(input int i);
        if (i == 0)    return 16'h4101;
        if (i == 1)    return 16'h0001;
        if (i == 'h20) return 16'hA5A5;
        return 16'(i * 40503 + 4951);
    endfunction

    // RAM model: registered read, write-first, preloaded on the first edge.
    logic [15:0] ram [0:RAM_DEPTH-1];
    bit          ram_loaded = 1'b0;
    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < RAM_DEPTH; i++) ram[i] <= init_val(i);
            ram_loaded <= 1'b1;
        end else if (bus.Mem_Enable) begin
            if (bus.Mem_Write_Enab) begin
                ram[bus.Mem_Add] <= bus.Mem_Wdata;
                bus.Mem_Rdata    <= bus.Mem_Wdata;
            end else begin
                bus.Mem_Rdata <= ram[bus.Mem_Add];
            end
        end
    end

    logic [15:0] ref_mem [0:RAM_DEPTH-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    int cyc = 0;
    int n_acc = 0;
    int acc_last = 0;
    int acc_prev = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && bus.Req_Valid && bus.Req_Ready) begin
            n_acc    <= n_acc + 1;
            acc_prev <= acc_last;
            acc_last <= cyc;
        end
    end

    int en_cycles = 0;
    int we_cycles = 0;
    always @(negedge clk) begin
        if (bus.Mem_Enable)     en_cycles <= en_cycles + 1;
        if (bus.Mem_Write_Enab) begin
            we_cycles <= we_cycles + 1;
            chk("we_without_en", {31'd0, bus.Mem_Enable}, 32'd1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Issue one request, wait for its response, optionally stall, then take it.
    task automatic run_txn(input string tag, input logic wr, input logic [15:0] a,
                           input logic [15:0] d, input int stall,
                           output logic [15:0] rd, output logic er, output int lat,
                           output int den, output int dwe);
        int e0, w0, n;
        @(negedge clk);
        n = 0;
        while (!bus.Req_Ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_req_ready"}, {31'd0, bus.Req_Ready}, 32'd1);
        e0 = en_cycles;
        w0 = we_cycles;
        bus.Req_Valid = 1'b1;
        bus.Req_Write = wr;
        bus.Req_Addr  = a;
        bus.Req_Wdata = d;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            bus.Req_Valid = 1'b0;
        end while (!bus.Rsp_Valid && lat < 20);
        rd = bus.Rsp_Rdata;
        er = bus.Rsp_Err;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk({tag, "_hold"}, {14'd0, bus.Rsp_Valid, bus.Rsp_Err, bus.Rsp_Rdata},
                {14'd0, 1'b1, er, rd});
        end
        bus.Rsp_Ready = 1'b1;
        @(negedge clk);
        bus.Rsp_Ready = 1'b0;
        chk({tag, "_rsp_taken"}, {30'd0, bus.Rsp_Valid, bus.Req_Ready}, {30'd0, 1'b0, 1'b1});
        den = en_cycles - e0;
        dwe = we_cycles - w0;
    endtask

    function automatic bit model_err(input logic [15:0] a);
`ifdef DMEM_ERR_CHECK_EN
        return (a >= 16'(RAM_DEPTH));
`else
        return 1'b0;
`endif
    endfunction

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_en;
        int          exp_we;
    } vec_t;

    vec_t vec [7];

    initial begin
        logic [15:0] rd, a, d, exp_rd;
        logic        er, wr, exp_er;
        int          lat, den, dwe, n, a0, e0, w0, idx, stall, exp_lat;

        vec[0] = '{1'b1, 16'h0005, 16'hBEEF, 16'h0000, 1'b0, 2, 1, 1};
        vec[1] = '{1'b0, 16'h0005, 16'h0000, 16'hBEEF, 1'b0, 3, 1, 0};
        vec[2] = '{1'b0, 16'h0000, 16'h0000, 16'h4101, 1'b0, 3, 1, 0};
`ifdef DMEM_ERR_CHECK_EN
        vec[3] = '{1'b0, 16'h0400, 16'h0000, 16'h0000, 1'b1, 1, 0, 0};
`else
        vec[3] = '{1'b0, 16'h0400, 16'h0000, 16'h4101, 1'b0, 3, 1, 0};
`endif
        vec[4] = '{1'b1, 16'h03FF, 16'h1234, 16'h0000, 1'b0, 2, 1, 1};
        vec[5] = '{1'b0, 16'h03FF, 16'h0000, 16'h1234, 1'b0, 3, 1, 0};
        vec[6] = '{1'b0, 16'h0001, 16'h0000, 16'h0001, 1'b0, 3, 1, 0};

        for (int i = 0; i < RAM_DEPTH; i++) ref_mem[i] = init_val(i);

        rst           = 1'b1;
        bus.Req_Valid = 1'b0;
        bus.Req_Write = 1'b0;
        bus.Req_Addr  = '0;
        bus.Req_Wdata = '0;
        bus.Rsp_Ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs",
            {bus.Req_Ready, bus.Rsp_Valid, bus.Rsp_Err, bus.Mem_Enable, bus.Mem_Write_Enab,
             bus.Rsp_Rdata | bus.Mem_Wdata, 11'd0},
            {1'b1, 4'b0000, 16'h0000, 11'd0});
        chk("reset_mem_add", {22'd0, bus.Mem_Add}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_txn($sformatf("vec%0d", i), vec[i].wr, vec[i].addr, vec[i].wdata, 0,
                    rd, er, lat, den, dwe);
            chk($sformatf("vec%0d_rdata", i), {16'd0, rd}, {16'd0, vec[i].exp_rdata});
            chk($sformatf("vec%0d_err", i), {31'd0, er}, {31'd0, vec[i].exp_err});
            chk($sformatf("vec%0d_lat", i), lat, vec[i].exp_lat);
            chk($sformatf("vec%0d_en_cycles", i), den, vec[i].exp_en);
            chk($sformatf("vec%0d_we_cycles", i), dwe, vec[i].exp_we);
            if (vec[i].wr && !model_err(vec[i].addr))
                ref_mem[vec[i].addr[9:0]] = vec[i].wdata;
        end

        // Stalled load response; a request arriving meanwhile must be dropped.
        @(negedge clk);
        a0 = n_acc;
        e0 = en_cycles;
        w0 = we_cycles;
        bus.Req_Valid = 1'b1;
        bus.Req_Write = 1'b0;
        bus.Req_Addr  = 16'h0020;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            bus.Req_Valid = 1'b0;
        end while (!bus.Rsp_Valid && lat < 20);
        chk("stall_lat", lat, 3);
        chk("stall_rdata", {16'd0, bus.Rsp_Rdata}, 32'h0000A5A5);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) begin
                bus.Req_Valid = 1'b1;
                bus.Req_Write = 1'b1;
                bus.Req_Addr  = 16'h0021;
                bus.Req_Wdata = 16'hDEAD;
            end
            chk("stall_hold", {14'd0, bus.Rsp_Valid, bus.Req_Ready, bus.Rsp_Rdata},
                {14'd0, 1'b1, 1'b0, 16'hA5A5});
        end
        bus.Req_Valid = 1'b0;
        bus.Rsp_Ready = 1'b1;
        @(negedge clk);
        bus.Rsp_Ready = 1'b0;
        chk("stall_accepts", n_acc - a0, 1);
        chk("stall_en_cycles", en_cycles - e0, 1);
        chk("stall_we_cycles", we_cycles - w0, 0);
        run_txn("stall_readback", 1'b0, 16'h0021, 16'h0, 0, rd, er, lat, den, dwe);
        chk("stall_readback_rdata", {16'd0, rd}, {16'd0, ref_mem['h21]});

        // Reset asserted between edges while a store is in ACCESS.
        @(negedge clk);
        bus.Req_Valid = 1'b1;
        bus.Req_Write = 1'b1;
        bus.Req_Addr  = 16'h0010;
        bus.Req_Wdata = 16'hFFFF;
        @(negedge clk);
        bus.Req_Valid = 1'b0;
        chk("rst_pre_access", {30'd0, bus.Mem_Enable, bus.Mem_Write_Enab}, 32'd3);
        #1 rst = 1'b1;
        #1;
        chk("rst_async_outputs",
            {26'd0, bus.Mem_Enable, bus.Mem_Write_Enab, bus.Req_Ready, bus.Rsp_Valid,
             (bus.Mem_Add != 10'd0), (bus.Mem_Wdata != 16'd0)},
            {26'd0, 6'b001000});
        @(negedge clk);
        rst = 1'b0;
        chk("rst_release_ready", {31'd0, bus.Req_Ready}, 32'd1);
        run_txn("post_rst_load", 1'b0, 16'h0005, 16'h0, 0, rd, er, lat, den, dwe);
        chk("post_rst_rdata", {16'd0, rd}, {16'd0, ref_mem[5]});
        chk("post_rst_lat", lat, 3);
        run_txn("post_rst_store", 1'b1, 16'h0010, 16'h0F0F, 0, rd, er, lat, den, dwe);
        ref_mem['h10] = 16'h0F0F;

        // Back-to-back stores with Rsp_Ready tied high.
        bus.Rsp_Ready = 1'b1;
        @(negedge clk);
        a0 = n_acc;
        bus.Req_Valid = 1'b1;
        bus.Req_Write = 1'b1;
        bus.Req_Addr  = 16'h03FF;
        bus.Req_Wdata = 16'h7E57;
        n = 0;
        while (n_acc != a0 + 1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        bus.Req_Addr  = 16'h0000;
        bus.Req_Wdata = 16'h55AA;
        n = 0;
        while (n_acc != a0 + 2 && n < 20) begin
            @(negedge clk);
            n++;
        end
        bus.Req_Valid = 1'b0;
        chk("b2b_accepts", n_acc - a0, 2);
        chk("b2b_store_period", acc_last - acc_prev, 3);
        repeat (3) @(negedge clk);
        bus.Rsp_Ready = 1'b0;
        ref_mem['h3FF] = 16'h7E57;
        ref_mem[0]     = 16'h55AA;
        run_txn("b2b_rb0", 1'b0, 16'h03FF, 16'h0, 0, rd, er, lat, den, dwe);
        chk("b2b_rb0_rdata", {16'd0, rd}, 32'h00007E57);
        run_txn("b2b_rb1", 1'b0, 16'h0000, 16'h0, 0, rd, er, lat, den, dwe);
        chk("b2b_rb1_rdata", {16'd0, rd}, 32'h000055AA);

        // Randomized traffic against the reference memory.
        for (int i = 0; i < 40; i++) begin
            wr    = 1'($urandom_range(0, 1));
            a     = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, RAM_DEPTH - 1));
            d     = 16'($urandom);
            stall = $urandom_range(0, 2);
            exp_er = model_err(a);
            idx    = int'(a) % RAM_DEPTH;
            if (exp_er) begin
                exp_rd  = 16'h0000;
                exp_lat = 1;
            end else if (wr) begin
                exp_rd  = 16'h0000;
                exp_lat = 2;
            end else begin
                exp_rd  = ref_mem[idx];
                exp_lat = 3;
            end
            run_txn($sformatf("rnd%0d", i), wr, a, d, stall, rd, er, lat, den, dwe);
            chk($sformatf("rnd%0d_rdata", i), {16'd0, rd}, {16'd0, exp_rd});
            chk($sformatf("rnd%0d_err", i), {31'd0, er}, {31'd0, exp_er});
            chk($sformatf("rnd%0d_lat", i), lat, exp_lat);
            chk($sformatf("rnd%0d_we", i), dwe, (wr && !exp_er) ? 1 : 0);
            if (wr && !exp_er) ref_mem[idx] = d;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
